// File: rtl/status_serial_rx.sv
// rtl/status_serial_rx.sv - 4-bit framed status receiver with inter-frame gap check.
// Optional link watchdog is built when STATUS_RX_WATCHDOG_EN is defined.
module status_serial_rx #(
  parameter int unsigned SB       = 3,
  parameter int unsigned WD_COUNT = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       status_send_i,
  input  logic       status_in_i,
  output logic [3:0] msg_o,
  output logic       msg_valid_o,
  output logic       armed_o,
  output logic       alarm_o,
  output logic       sens1_o,
  output logic       sens2_o,
  output logic       frame_err_o,
  output logic       illegal_o,
  output logic       link_lost_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  localparam logic [3:0] GAP_LAST = (SB == 0) ? 4'd0 : 4'(SB - 1);

  state_e     state_q;
  logic [1:0] bit_cnt_q;
  logic [3:0] gap_cnt_q;
  logic [3:0] shift_q;
  logic [3:0] shift_d;
  logic       pend_q;
  logic [3:0] msg_q;
  logic       msg_valid_q;
  logic       frame_err_q;
  logic       illegal_q;

  // LSB arrives first, so shifting right leaves it in bit 0 after four bits.
  assign shift_d = {status_in_i, shift_q[3:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 2'd0;
      gap_cnt_q   <= 4'd0;
      shift_q     <= 4'd0;
      pend_q      <= 1'b0;
      msg_q       <= 4'd0;
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      pend_q      <= 1'b0;
      // A completed frame is published one cycle after its last bit.
      if (pend_q) begin
        msg_q       <= shift_q;
        illegal_q   <= shift_q[1] & ~shift_q[0];
        msg_valid_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (status_send_i) begin
            bit_cnt_q <= 2'd0;
            shift_q   <= 4'd0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (status_send_i) begin
            frame_err_q <= 1'b1;
            bit_cnt_q   <= 2'd0;
            shift_q     <= 4'd0;
          end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 2'd1;
            if (bit_cnt_q == 2'd3) begin
              pend_q    <= 1'b1;
              gap_cnt_q <= 4'd0;
              state_q   <= (SB == 0) ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          if (status_send_i) begin
            frame_err_q <= 1'b1;
            bit_cnt_q   <= 2'd0;
            state_q     <= SHIFT;
          end else if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign msg_o       = msg_q;
  assign msg_valid_o = msg_valid_q;
  assign armed_o     = msg_q[0];
  assign alarm_o     = msg_q[1];
  assign sens1_o     = msg_q[2];
  assign sens2_o     = msg_q[3];
  assign frame_err_o = frame_err_q;
  assign illegal_o   = illegal_q;

`ifdef STATUS_RX_WATCHDOG_EN
  logic [15:0] wd_q;

  // Cleared on the same edge that raises msg_valid, so link_lost drops with the pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= 16'd0;
    end else if (pend_q) begin
      wd_q <= 16'd0;
    end else if (wd_q != 16'hFFFF) begin
      wd_q <= wd_q + 16'd1;
    end
  end

  assign link_lost_o = (wd_q >= 16'(WD_COUNT));
`else
  // WD_COUNT is at least 2, so this is constant low.
  assign link_lost_o = (WD_COUNT == 0);
`endif

endmodule
